wb_led_seq: RTL

- Multi-channel Wishbone-controlled LED pattern sequencer; generalised successor to the single-channel static bit-select LED block.
- Each channel holds a pattern word, a position pointer and a config; a shared prescaler tick can auto-advance the pointer with wrap at a programmable length.
- Sits on the user-area Wishbone bus as a slave; outputs drive GPIO LEDs directly.

---
 rtl/wb_led_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_led_seq.sv
// wb_led_seq: Wishbone slave driving N_CH LED channels, each stepping through a pattern word.
// Define LED_PWM_EN to add a per-channel 8-bit brightness register and a shared PWM counter.
module wb_led_seq #(
    parameter int N_CH    = 4,
    parameter int PAT_W   = 32,
    parameter int PRESC_W = 24
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    output logic [N_CH-1:0] o_led,
    input  logic [31:0]     i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic [3:0]      i_wb_sel,
    input  logic            i_wb_we,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    output logic [31:0]     o_wb_dat,
    output logic            o_wb_ack
);

    localparam int POS_W = $clog2(PAT_W);
    localparam int IDX_W = $clog2(4 + 4 * N_CH);
    localparam int GRP_W = IDX_W - 2;

    logic [IDX_W-1:0]   idx;
    logic [GRP_W-1:0]   grp;
    logic [1:0]         sub;
    logic               req;
    logic               wr;
    logic               ctrl_wr;
    logic               presc_wr;
    logic               tick;

    logic               run;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;

    logic [PAT_W-1:0]   pattern [N_CH];
    logic [POS_W-1:0]   pos     [N_CH];
    logic [POS_W-1:0]   len     [N_CH];
    logic [N_CH-1:0]    auto_en;
    logic [N_CH-1:0]    invert;

    logic [N_CH-1:0]    ch_hit;
    logic [N_CH-1:0]    pat_wr;
    logic [N_CH-1:0]    pos_wr;
    logic [N_CH-1:0]    cfg_wr;
    logic [N_CH-1:0]    pwm_gate;
    logic [N_CH-1:0]    led_nxt;
    logic [31:0]        rdata;

    // Byte selects and address bits outside the register index carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, i_wb_sel, i_wb_adr[31:IDX_W+2], i_wb_adr[1:0], i_wb_dat};

    // Index group 0 holds the globals; group c+1 holds channel c.
    assign idx      = i_wb_adr[IDX_W+1:2];
    assign grp      = idx[IDX_W-1:2];
    assign sub      = idx[1:0];
    assign req      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr       = req & i_wb_we;
    assign ctrl_wr  = wr && (grp == '0) && (sub == 2'd0);
    assign presc_wr = wr && (grp == '0) && (sub == 2'd1);

    always_comb begin
        ch_hit = '0;
        pat_wr = '0;
        pos_wr = '0;
        cfg_wr = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_hit[c] = (grp == GRP_W'(c + 1));
            pat_wr[c] = wr & ch_hit[c] & (sub == 2'd0);
            pos_wr[c] = wr & ch_hit[c] & (sub == 2'd1);
            cfg_wr[c] = wr & ch_hit[c] & (sub == 2'd2);
        end
    end

    // A PRESCALE write restarts the count, so it must not also fire a tick.
    assign tick = run && (presc_cnt == '0) && !presc_wr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run       <= 1'b0;
            prescale  <= '0;
            presc_cnt <= '0;
        end else begin
            if (ctrl_wr)
                run <= i_wb_dat[0];
            if (presc_wr) begin
                prescale  <= i_wb_dat[PRESC_W-1:0];
                presc_cnt <= i_wb_dat[PRESC_W-1:0];
            end else if (!run || presc_cnt == '0) begin
                presc_cnt <= prescale;
            end else begin
                presc_cnt <= presc_cnt - PRESC_W'(1);
            end
        end
    end

    // A bus write to POS takes priority over the auto advance on the same edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                pattern[c] <= '0;
                pos[c]     <= '0;
                len[c]     <= '0;
            end
            auto_en <= '0;
            invert  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (pat_wr[c])
                    pattern[c] <= i_wb_dat[PAT_W-1:0];
                if (pos_wr[c])
                    pos[c] <= i_wb_dat[POS_W-1:0];
                else if (tick && auto_en[c])
                    pos[c] <= (pos[c] >= len[c]) ? '0 : pos[c] + POS_W'(1);
                if (cfg_wr[c]) begin
                    len[c]     <= i_wb_dat[POS_W-1:0];
                    auto_en[c] <= i_wb_dat[8];
                    invert[c]  <= i_wb_dat[9];
                end
            end
        end
    end

`ifdef LED_PWM_EN
    logic [7:0]      pwm_cnt;
    logic [7:0]      bright [N_CH];
    logic [N_CH-1:0] brt_wr;

    always_comb begin
        brt_wr = '0;
        for (int c = 0; c < N_CH; c++)
            brt_wr[c] = wr & ch_hit[c] & (sub == 2'd3);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt <= '0;
            for (int c = 0; c < N_CH; c++)
                bright[c] <= 8'hFF;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            for (int c = 0; c < N_CH; c++)
                if (brt_wr[c])
                    bright[c] <= i_wb_dat[7:0];
        end
    end

    // Full brightness 0xFF still leaves one dark slot per 256-cycle period.
    always_comb begin
        pwm_gate = '0;
        for (int c = 0; c < N_CH; c++)
            pwm_gate[c] = (pwm_cnt < bright[c]);
    end
`else
    always_comb begin
        pwm_gate = '1;
    end
`endif

    always_comb begin
        rdata = '0;
        if (grp == '0) begin
            case (sub)
                2'd0:    rdata[0] = run;
                2'd1:    rdata[PRESC_W-1:0] = prescale;
                default: ;
            endcase
        end
        for (int c = 0; c < N_CH; c++) begin
            if (ch_hit[c]) begin
                case (sub)
                    2'd0: rdata[PAT_W-1:0] = pattern[c];
                    2'd1: rdata[POS_W-1:0] = pos[c];
                    2'd2: begin
                        rdata[POS_W-1:0] = len[c];
                        rdata[8]         = auto_en[c];
                        rdata[9]         = invert[c];
                    end
`ifdef LED_PWM_EN
                    2'd3: rdata[7:0] = bright[c];
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int c = 0; c < N_CH; c++)
            led_nxt[c] = (pattern[c][pos[c]] & pwm_gate[c]) ^ invert[c];
    end

    // Gating on !o_wb_ack makes every transfer a single-cycle ack, so back-to-back strobes alternate.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_led    <= '0;
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            o_led    <= led_nxt;
            o_wb_ack <= req;
            if (req)
                o_wb_dat <= rdata;
        end
    end

endmodule
